wb_write_arbiter: RTL and testbench

- Producer side of the register-file write port (write enable, write index, write data).
- Merges two result sources onto the single write port: in-order pipeline writeback, and a long-latency unit (MUL/DIV, later misses) whose results return out of order.
- Keeps a busy-register scoreboard so decode can interlock on pending long-latency destinations.
- Sits between MEM/WB and the register file.

---
 rtl/wb_write_arbiter_pkg.sv | 11 +
 rtl/wb_write_arbiter_if.sv | 25 ++
 rtl/wb_scoreboard.sv | 22 ++
 rtl/wb_write_arbiter.sv | 63 ++++++
 tb/tb_wb_write_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// wb_write_arbiter_pkg: shared writeback types and constants for the register-file write port
package wb_write_arbiter_pkg;
  localparam int CORE_XLEN = 32;
  localparam int NUM_REGS = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic valid;
    logic [4:0] rd;
    logic [CORE_XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_write_arbiter_if.sv
// wb_write_arbiter_if: writeback sources, issue tap, scoreboard and register-file write port
interface wb_write_arbiter_if #(parameter int XLEN = wb_write_arbiter_pkg::CORE_XLEN);
  logic pipe_valid;
  logic [4:0] pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic pipe_ready;
  logic lu_valid;
  logic [4:0] lu_rd;
  logic [XLEN-1:0] lu_data;
  logic lu_ready;
  logic issue_valid;
  logic [4:0] issue_rd;
  logic [31:0] busy_mask;
  logic reg_write;
  logic [4:0] write_reg;
  logic [XLEN-1:0] write_data;
  modport slave (
    input pipe_valid, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data, issue_valid, issue_rd,
    output pipe_ready, lu_ready, busy_mask, reg_write, write_reg, write_data
  );
  modport master (
    output pipe_valid, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data, issue_valid, issue_rd,
    input pipe_ready, lu_ready, busy_mask, reg_write, write_reg, write_data
  );
endinterface

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: busy bit per register awaiting a long-latency result; a same-cycle set beats clear
module wb_scoreboard
  import wb_write_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_set,
  input  logic [4:0] i_set_rd,
  input  logic i_clr,
  input  logic [4:0] i_clr_rd,
  output logic [NUM_REGS-1:0] o_busy
);
  logic [NUM_REGS-1:0] r_busy, w_set, w_clr;
  always_comb begin
    w_set = (i_set && i_set_rd != REG_ZERO) ? NUM_REGS'(1) << i_set_rd : '0;
    w_clr = i_clr ? NUM_REGS'(1) << i_clr_rd : '0;
  end
  always_ff @(posedge clk)
    if (reset) r_busy <= '0;
    else r_busy <= (r_busy & ~w_clr) | w_set;
  assign o_busy = r_busy;
endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges pipeline and long-latency results onto one register-file write port
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN = CORE_XLEN
) (
  input logic clk,
  input logic reset,
  wb_write_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  wb_req_t r_hold;
  logic [SW-1:0] r_starve;
  logic r_we;
  logic [4:0] r_wr;
  logic [XLEN-1:0] r_wd;
  logic w_force, w_grant_hold, w_grant_pipe, w_lu_take;
  logic [NUM_REGS-1:0] w_busy;
  wb_req_t w_win;
  always_comb begin
    w_force = r_hold.valid && r_starve == SW'(STARVE_LIMIT);
    w_grant_hold = r_hold.valid && (!bus.pipe_valid || w_force);
    w_grant_pipe = bus.pipe_valid && !w_force;
    w_win = w_grant_hold ? r_hold : {w_grant_pipe, bus.pipe_rd, bus.pipe_data};
    w_lu_take = bus.lu_valid && bus.lu_ready;
  end
  assign bus.pipe_ready = !reset && !w_force;
  assign bus.lu_ready = !reset && (!r_hold.valid || w_grant_hold);
  always_ff @(posedge clk)
    if (reset) begin
      r_hold <= '0;
      r_starve <= '0;
      r_we <= 1'b0;
      r_wr <= '0;
      r_wd <= '0;
    end else begin
      r_hold.valid <= w_lu_take || (r_hold.valid && !w_grant_hold);
      if (w_lu_take) begin
        r_hold.rd <= bus.lu_rd;
        r_hold.data <= bus.lu_data;
      end
      r_starve <= (!r_hold.valid || w_grant_hold) ? '0 : r_starve + SW'(r_starve != SW'(STARVE_LIMIT));
      r_we <= w_win.valid && w_win.rd != REG_ZERO;
      if (w_win.valid) begin
        r_wr <= w_win.rd;
        r_wd <= w_win.data;
      end
    end
  wb_scoreboard u_sb (
    .clk(clk),
    .reset(reset),
    .i_set(bus.issue_valid),
    .i_set_rd(bus.issue_rd),
    .i_clr(w_grant_hold),
    .i_clr_rd(r_hold.rd),
    .o_busy(w_busy)
  );
  assign bus.busy_mask = w_busy;
  assign bus.reg_write = r_we;
  assign bus.write_reg = r_wr;
  assign bus.write_data = r_wd;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed scenarios plus random traffic checked every cycle against a queue-based model
module tb_wb_write_arbiter;
  localparam int LIM = 4;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  wb_write_arbiter_if bus ();
  wb_write_arbiter #(.STARVE_LIMIT(LIM)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [4:0] q_rd[$];
  logic [31:0] q_data[$];
  int loss = 0;
  logic [31:0] m_busy = 0;
  logic m_we = 0;
  logic [4:0] m_wr = 0;
  logic [31:0] m_wd = 0;
  logic m_pipe_acc = 0;
  logic m_lu_acc = 0;
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask
  // Model: the hold buffer is a queue of at most one entry; loss counts consecutive lost arbitrations.
  always @(posedge clk) begin
    bit hv, frc, th, tp;
    if (reset) begin
      q_rd.delete();
      q_data.delete();
      loss = 0;
      m_busy = 0;
      m_we = 0;
      m_wr = 0;
      m_wd = 0;
      m_pipe_acc = 0;
      m_lu_acc = 0;
    end else begin
      hv = q_rd.size() != 0;
      frc = hv && loss >= LIM;
      th = hv && (!bus.pipe_valid || frc);
      tp = bus.pipe_valid && !frc;
      m_pipe_acc = tp;
      m_lu_acc = bus.lu_valid && (!hv || th);
      m_we = 0;
      if (th) begin
        m_wr = q_rd.pop_front();
        m_wd = q_data.pop_front();
        m_we = m_wr != 0;
        m_busy[m_wr] = 0;
      end else if (tp) begin
        m_wr = bus.pipe_rd;
        m_wd = bus.pipe_data;
        m_we = m_wr != 0;
      end
      if (bus.issue_valid && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1;
      loss = (hv && !th) ? ((loss + 1 > LIM) ? LIM : loss + 1) : 0;
      if (m_lu_acc) begin
        q_rd.push_back(bus.lu_rd);
        q_data.push_back(bus.lu_data);
      end
    end
  end
  always @(negedge clk) begin
    bit hv, frc;
    hv = q_rd.size() != 0;
    frc = hv && loss >= LIM;
    chk("reg_write", bus.reg_write, m_we);
    chk("write_reg", bus.write_reg, m_wr);
    chk("write_data", bus.write_data, m_wd);
    chk("busy_mask", bus.busy_mask, m_busy);
    chk("pipe_ready", bus.pipe_ready, !reset && !frc);
    chk("lu_ready", bus.lu_ready, !reset && (!hv || !bus.pipe_valid || frc));
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic idle();
    bus.pipe_valid = 0;
    bus.lu_valid = 0;
    bus.issue_valid = 0;
  endtask
  task automatic wr_is(string name, logic we, logic [4:0] rd, logic [31:0] d);
    chk({name, "_we"}, bus.reg_write, we);
    chk({name, "_rd"}, bus.write_reg, rd);
    chk({name, "_data"}, bus.write_data, d);
  endtask
  initial begin
    bus.pipe_valid = 1; bus.pipe_rd = 4; bus.pipe_data = 32'h44;
    bus.lu_valid = 1; bus.lu_rd = 6; bus.lu_data = 32'h66;
    bus.issue_valid = 0; bus.issue_rd = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_we", bus.reg_write, 0);
      chk("rst_busy", bus.busy_mask, 0);
      #1;
      chk("rst_pipe_ready", bus.pipe_ready, 0);
      chk("rst_lu_ready", bus.lu_ready, 0);
    end
    reset = 0;
    bus.lu_valid = 0;
    #1 chk("rel_pipe_ready", bus.pipe_ready, 1);
    tick();
    wr_is("first", 1, 4, 32'h44);
    bus.pipe_rd = 5; bus.pipe_data = 32'hA5A5A5A5;
    tick();
    wr_is("pipe5", 1, 5, 32'hA5A5A5A5);
    bus.pipe_rd = 0; bus.pipe_data = 32'hFFFFFFFF;
    #1 chk("pipe_x0_ready", bus.pipe_ready, 1);
    tick();
    chk("pipe_x0_we", bus.reg_write, 0);
    idle();
    bus.issue_valid = 1; bus.issue_rd = 7;
    tick();
    chk("sb_set7", bus.busy_mask, 32'h80);
    bus.issue_valid = 0;
    tick();
    bus.lu_valid = 1; bus.lu_rd = 7; bus.lu_data = 32'h12345678;
    #1 chk("sb_lu_ready", bus.lu_ready, 1);
    tick();
    chk("sb_still_busy", bus.busy_mask, 32'h80);
    bus.lu_valid = 0;
    tick();
    wr_is("sb_wr7", 1, 7, 32'h12345678);
    chk("sb_clr7", bus.busy_mask, 0);
    chk("model_wr7", m_wr, 7);
    bus.lu_valid = 1; bus.lu_rd = 9; bus.lu_data = 32'h99;
    bus.pipe_valid = 1;
    for (int k = 0; k < 5; k++) begin
      bus.pipe_rd = 5'(10 + k); bus.pipe_data = 32'h100 + k;
      #1 chk("starve_ready", bus.pipe_ready, 1);
      tick();
      bus.lu_valid = 0;
      wr_is("starve_pipe", 1, 5'(10 + k), 32'h100 + k);
    end
    bus.pipe_rd = 15; bus.pipe_data = 32'h105;
    chk("model_loss", loss, LIM);
    #1 chk("force_ready", bus.pipe_ready, 0);
    tick();
    wr_is("force_hold9", 1, 9, 32'h99);
    #1 chk("resume_ready", bus.pipe_ready, 1);
    tick();
    wr_is("resume15", 1, 15, 32'h105);
    idle();
    bus.lu_valid = 1; bus.lu_rd = 3; bus.lu_data = 32'h33;
    tick();
    bus.lu_valid = 0;
    bus.issue_valid = 1; bus.issue_rd = 3;
    tick();
    wr_is("setclr3", 1, 3, 32'h33);
    chk("setclr_busy", bus.busy_mask, 32'h8);
    bus.issue_valid = 0;
    tick();
    chk("setclr_busy_kept", bus.busy_mask, 32'h8);
    for (int k = 1; k <= 4; k++) begin
      bus.lu_valid = k < 4; bus.lu_rd = 5'(k); bus.lu_data = 32'h10 * k;
      if (k < 4) #1 chk("b2b_lu_ready", bus.lu_ready, 1);
      tick();
      if (k > 1) wr_is("b2b", 1, 5'(k - 1), 32'h10 * (k - 1));
    end
    idle();
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset = $urandom_range(0, 199) == 0;
      if (!(bus.pipe_valid && !m_pipe_acc)) begin
        bus.pipe_valid = $urandom_range(0, 2) != 0;
        bus.pipe_rd = 5'($urandom_range(0, 31));
        bus.pipe_data = $urandom;
      end
      if (!(bus.lu_valid && !m_lu_acc)) begin
        bus.lu_valid = $urandom_range(0, 2) == 0;
        bus.lu_rd = 5'($urandom_range(0, 31));
        bus.lu_data = $urandom;
      end
      bus.issue_valid = $urandom_range(0, 3) == 0;
      bus.issue_rd = 5'($urandom_range(0, 31));
    end
    reset = 0;
    idle();
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
